// File: rtl/commit_unit.sv
// In-order retirement stage: pops the ROB head, writes the architectural regfile,
// releases head stores and raises mispredict flushes. Optional perf counters: COMMIT_PERF_CNT_EN.
module commit_unit #(
    parameter int ROB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_valid,
    input  logic                 rob_ready,
    input  logic [4:0]           commit_rd_s,
    input  logic [31:0]          commit_rd_v,
    input  logic [ROB_DEPTH-1:0] commit_rob,
    input  logic [6:0]           commit_opcode,
    input  logic                 flush_branch,
    input  logic [31:0]          pc_branch_target,
    input  logic [63:0]          order_branch_target,
    output logic                 rob_pop,
    output logic                 regf_we,
    output logic [4:0]           regf_rd_s,
    output logic [31:0]          regf_rd_v,
    output logic [ROB_DEPTH-1:0] regf_rob,
    output logic                 store_commit_req,
    input  logic                 store_commit_ack,
    output logic                 move_flush,
    output logic [31:0]          flush_pc,
    output logic [63:0]          flush_order,
`ifdef COMMIT_PERF_CNT_EN
    output logic [63:0]          perf_retired,
    output logic [31:0]          perf_flushes,
`endif
    output logic [1:0]           dbg_state
);

    localparam logic [6:0] BR_OPCODE    = 7'b1100011;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] flush_pc_q, flush_pc_d;
    logic [63:0] flush_order_q, flush_order_d;
    logic        committable;
    logic        is_store;

    assign committable = rob_valid & rob_ready;
    assign is_store    = (commit_opcode == STORE_OPCODE);

    // Handshake: store_commit_req stays high until store_commit_ack is seen in
    // the same cycle; that cycle is the one in which the store retires.
    always_comb begin
        state_d          = state_q;
        flush_pc_d       = flush_pc_q;
        flush_order_d    = flush_order_q;
        rob_pop          = 1'b0;
        store_commit_req = 1'b0;
        move_flush       = 1'b0;
        case (state_q)
            RUN: begin
                if (committable) begin
                    if (is_store) begin
                        // A store never redirects, so flush_branch is ignored here.
                        store_commit_req = 1'b1;
                        if (store_commit_ack) rob_pop = 1'b1;
                        else                  state_d = STORE_WAIT;
                    end else begin
                        rob_pop = 1'b1;
                        if (flush_branch) begin
                            flush_pc_d    = pc_branch_target;
                            flush_order_d = order_branch_target;
                            state_d       = FLUSH;
                        end
                    end
                end
            end
            STORE_WAIT: begin
                store_commit_req = 1'b1;
                if (store_commit_ack) begin
                    rob_pop = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                move_flush = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
        // A reset cycle abandons whatever was in flight.
        if (!rst) begin
            rob_pop          = 1'b0;
            store_commit_req = 1'b0;
            move_flush       = 1'b0;
        end
        regf_we = rob_pop && (commit_rd_s != 5'd0) &&
                  (commit_opcode != BR_OPCODE) && !is_store;
    end

    assign regf_rd_s   = commit_rd_s;
    assign regf_rd_v   = commit_rd_v;
    assign regf_rob    = commit_rob;
    assign flush_pc    = flush_pc_q;
    assign flush_order = flush_order_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            flush_pc_q    <= '0;
            flush_order_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_pc_q    <= flush_pc_d;
            flush_order_q <= flush_order_d;
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_retired_d = perf_retired_q + {63'd0, rob_pop};
        perf_flushes_d = perf_flushes_q + {31'd0, move_flush};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_retired_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 4, meaning ROB index width in bits.
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 SHALL have ports: rst  input  1  one clock; reset is synchronous and active-low (asserted when 0, sampled on rising clk).
REQ-004 SHALL have inputs from ROB head: rob_valid 1, rob_ready 1, commit_rd_s 5, commit_rd_v 32, commit_rob ROB_DEPTH, commit_opcode 7, flush_branch 1, pc_branch_target 32, order_branch_target 64.
REQ-005 SHALL have output rob_pop 1: dequeue ROB head this cycle.
REQ-006 SHALL have outputs regf_we 1, regf_rd_s 5, regf_rd_v 32, regf_rob ROB_DEPTH: architectural regfile write and RAT-clear tag.
REQ-007 SHALL have output store_commit_req 1 and input store_commit_ack 1: release head store to the store queue / dmem.
REQ-008 SHALL have outputs move_flush 1, flush_pc 32, flush_order 64: pipeline-wide mispredict flush and fetch redirect.

Function
REQ-009 SHALL implement FSM states RUN, STORE_WAIT, FLUSH; at most one retirement per cycle.
REQ-010 Head committable SHALL mean rob_valid=1 and rob_ready=1; otherwise rob_pop=0, regf_we=0, state held.
REQ-011 In RUN, committable non-store head SHALL assert rob_pop combinationally in the same cycle (zero-cycle latency).
REQ-012 regf_we SHALL equal rob_pop AND commit_rd_s!=0 AND opcode not br_opcode/store_opcode; regf_rd_s/rd_v/rob SHALL pass commit_rd_s/rd_v/rob.
REQ-013 In RUN, committable head with opcode store_opcode SHALL assert store_commit_req; if store_commit_ack=1 same cycle, rob_pop=1 and stay RUN; else go STORE_WAIT without pop.
REQ-014 In STORE_WAIT, store_commit_req SHALL stay 1 until ack; on ack, rob_pop=1 that cycle, next state RUN; no other retirement in STORE_WAIT.
REQ-015 In RUN, committable head with flush_branch=1 (jal/jalr/br) SHALL pop and write link rd per REQ-012, capture pc_branch_target/order_branch_target into flush_pc/flush_order, next state FLUSH.
REQ-016 In FLUSH, move_flush SHALL be 1 for exactly one cycle, rob_pop=0, regf_we=0, store_commit_req=0, then return to RUN.
REQ-017 flush_pc/flush_order SHALL hold last captured values until next flush; move_flush=0 in all other states.
REQ-018 store_commit_ack while store_commit_req=0 SHALL be ignored.
REQ-019 A head store SHALL never carry flush_branch; if both set, store handling (REQ-013) SHALL take priority.

Reset
REQ-020 On rst=0 state SHALL become RUN; flush_pc, flush_order and counters SHALL clear to 0.
REQ-021 During reset cycle, rob_pop, regf_we, store_commit_req, move_flush SHALL be 0.
REQ-022 Reset in STORE_WAIT or FLUSH SHALL abandon the operation: no pop, req drops, no flush pulse.

Configuration
REQ-023 Macro COMMIT_PERF_CNT_EN defined SHALL add outputs perf_retired 64 (+1 per rob_pop) and perf_flushes 32 (+1 per move_flush), both wrapping, cleared by reset.
REQ-024 Without COMMIT_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-025 ADD head, rd_s=5, rd_v=0x1234, valid/ready=1 -> same cycle rob_pop=1, regf_we=1, regf_rd_s=5, regf_rd_v=0x1234.
REQ-026 Head rd_s=0 ALU op -> rob_pop=1, regf_we=0; head rob_ready=0 for 3 cycles -> rob_pop=0 for those cycles.
REQ-027 Store head, ack after 4 cycles -> store_commit_req=1 for 5 cycles, rob_pop=1 only in ack cycle; ack same cycle as req -> pop that cycle.
REQ-028 Mispredicted br, flush_branch=1, pc_branch_target=0x60000040, order_branch_target=17 -> pop, regf_we=0; next cycle move_flush=1, flush_pc=0x60000040, flush_order=17; following cycle move_flush=0.
REQ-029 rst=0 asserted in 2nd STORE_WAIT cycle -> next cycle store_commit_req=0, state RUN, no pop.
REQ-030 With COMMIT_PERF_CNT_EN, 10 retirements incl. one flush -> perf_retired=10, perf_flushes=1.
